// File: rtl/soc_uart_tx_if.sv
// Console write path and status signals of the UART transmitter.
// The CPU side drives bytes and the overflow clear; the transmitter reports line and FIFO state.
interface soc_uart_tx_if #(
   parameter int FIFO_DEPTH = 16
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic [7:0]       out_byte;
   logic             out_byte_en;
   logic             overflow_clr;
   logic             tx;
   logic             busy;
   logic [LVL_W-1:0] fifo_level;
   logic             overflow;

   modport master (
      output out_byte, out_byte_en, overflow_clr,
      input  tx, busy, fifo_level, overflow
   );

   modport slave (
      input  out_byte, out_byte_en, overflow_clr,
      output tx, busy, fifo_level, overflow
   );
endinterface

// File: rtl/soc_uart_tx.sv
// 8N1 UART transmitter with a byte FIFO in front of it.
// The FIFO is popped in IDLE or on the final STOP cycle, so queued frames go out back-to-back.
//
// state | meaning
// IDLE  | line high, waiting for a byte in the FIFO
// START | start bit (low) for CLK_DIV cycles
// DATA  | 8 data bits, LSB first, CLK_DIV cycles each
// STOP  | stop bit (high); last cycle pops the next byte if any
module soc_uart_tx #(
   parameter int CLK_DIV    = 868,
   parameter int FIFO_DEPTH = 16
) (
   input  logic         clk,
   input  logic         resetn,
   soc_uart_tx_if.slave bus
);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int LVL_W  = PTR_W + 1;
   localparam int BAUD_W = 16;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t            state;
   logic [BAUD_W-1:0] baud_cnt;
   logic [2:0]        bit_cnt;
   logic [7:0]        shreg;
   logic              tx_q;
   logic              ovf_q;

   logic [7:0]        mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [LVL_W-1:0]  level;

   logic baud_last;
   logic fifo_empty;
   logic fifo_full;
   logic pop;
   logic push;
   logic drop;

   assign baud_last  = (baud_cnt == BAUD_W'(CLK_DIV - 1));
   assign fifo_empty = (level == '0);
   assign fifo_full  = (level == LVL_W'(FIFO_DEPTH));
   assign pop        = !fifo_empty && ((state == S_IDLE) || ((state == S_STOP) && baud_last));
   // A full FIFO still accepts when the head leaves on the same edge.
   assign push       = bus.out_byte_en && (!fifo_full || pop);
   assign drop       = bus.out_byte_en && !push;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= bus.out_byte;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         if (drop) begin
            ovf_q <= 1'b1;
         end else if (bus.overflow_clr) begin
            ovf_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= S_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         tx_q     <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               tx_q     <= 1'b1;
               baud_cnt <= '0;
               bit_cnt  <= '0;
               if (pop) begin
                  shreg <= mem[rd_ptr];
                  tx_q  <= 1'b0;
                  state <= S_START;
               end
            end
            S_START: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  tx_q     <= shreg[0];
                  state    <= S_DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  if (bit_cnt == 3'd7) begin
                     bit_cnt <= '0;
                     tx_q    <= 1'b1;
                     state   <= S_STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     shreg   <= {1'b0, shreg[7:1]};
                     tx_q    <= shreg[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  if (pop) begin
                     shreg <= mem[rd_ptr];
                     tx_q  <= 1'b0;
                     state <= S_START;
                  end else begin
                     tx_q  <= 1'b1;
                     state <= S_IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               tx_q  <= 1'b1;
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.tx         = tx_q;
   assign bus.busy       = (state != S_IDLE) || !fifo_empty;
   assign bus.fifo_level = level;
   assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_soc_uart_tx.sv
// Bench for soc_uart_tx: a frame-level model (byte queue + position in a 10-bit frame)
// is compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_soc_uart_tx;
   localparam int CD    = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CD;

   logic clk    = 1'b0;
   logic resetn = 1'b0;

   soc_uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

   soc_uart_tx #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 40)
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // frame-level model
   logic [7:0] q[$];
   bit         m_active = 1'b0;
   int         m_n      = 0;
   logic [7:0] m_cur    = 8'h00;
   bit         m_ovf    = 1'b0;
   bit         m_pop;
   bit         m_acc;
   bit         m_drop;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         q.delete();
         m_active = 1'b0;
         m_n      = 0;
         m_ovf    = 1'b0;
      end else begin
         m_pop  = (q.size() != 0) && (!m_active || m_n == FRAME - 1);
         m_acc  = bus.out_byte_en && ((q.size() < DEPTH) || m_pop);
         m_drop = bus.out_byte_en && !m_acc;
         if (m_pop) begin
            m_cur    = q.pop_front();
            m_active = 1'b1;
            m_n      = 0;
         end else if (m_active) begin
            if (m_n == FRAME - 1) m_active = 1'b0;
            else m_n++;
         end
         if (m_acc) q.push_back(bus.out_byte);
         if (m_drop) m_ovf = 1'b1;
         else if (bus.overflow_clr) m_ovf = 1'b0;
      end
   end

   function automatic logic exp_tx();
      int idx;
      if (!m_active) return 1'b1;
      idx = m_n / CD;
      if (idx == 0) return 1'b0;
      if (idx == 9) return 1'b1;
      return m_cur[idx-1];
   endfunction

   always @(negedge clk) begin
      check("model_tx", 32'(bus.tx), 32'(exp_tx()));
      check("model_level", 32'(bus.fifo_level), 32'(q.size()));
      check("model_busy", 32'(bus.busy), 32'(m_active || q.size() != 0));
      check("model_overflow", 32'(bus.overflow), 32'(m_ovf));
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push_one(input logic [7:0] b);
      bus.out_byte    = b;
      bus.out_byte_en = 1'b1;
      @(negedge clk);
   endtask

   int a5_bits [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
   int cnt;

   initial begin
      bus.out_byte     = 8'h00;
      bus.out_byte_en  = 1'b0;
      bus.overflow_clr = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx", 32'(bus.tx), 1);
      check("rst_level", 32'(bus.fifo_level), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_overflow", 32'(bus.overflow), 0);
      resetn = 1'b1;
      @(negedge clk);

      // single 0xA5 frame from idle
      push_one(8'hA5);
      bus.out_byte_en = 1'b0;
      check("a5_latency_pre", 32'(bus.tx), 1);
      @(negedge clk);
      for (int i = 0; i < FRAME; i++) begin
         check("a5_bit", 32'(bus.tx), 32'(a5_bits[i/CD]));
         @(negedge clk);
      end
      check("a5_busy_after", 32'(bus.busy), 0);

      // two bytes back-to-back
      push_one(8'h01);
      push_one(8'h02);
      bus.out_byte_en = 1'b0;
      check("b2b_level", 32'(bus.fifo_level), 1);
      cnt = 0;
      while (bus.busy && cnt < 300) begin
         @(negedge clk);
         cnt++;
      end
      check("b2b_len", 32'(cnt), 80);

      // six pushes, one dropped
      for (int i = 0; i < 6; i++) push_one(8'(8'h10 + i));
      bus.out_byte_en = 1'b0;
      check("ovf_set", 32'(bus.overflow), 1);
      check("ovf_level", 32'(bus.fifo_level), 4);
      cnt = 0;
      while (bus.busy && cnt < 400) begin
         @(negedge clk);
         cnt++;
      end
      check("five_frames_len", 32'(cnt), 196);
      bus.overflow_clr = 1'b1;
      @(negedge clk);
      bus.overflow_clr = 1'b0;
      check("ovf_clr", 32'(bus.overflow), 0);

      // full FIFO, push on the STOP-final cycle
      for (int i = 0; i < 5; i++) push_one(8'(8'h20 + i));
      bus.out_byte_en = 1'b0;
      check("full_level", 32'(bus.fifo_level), 4);
      check("full_ovf", 32'(bus.overflow), 0);
      repeat (36) @(negedge clk);
      push_one(8'h99);
      check("stop_push_level", 32'(bus.fifo_level), 4);
      check("stop_push_ovf", 32'(bus.overflow), 0);

      // clear collides with a drop
      bus.out_byte     = 8'h77;
      bus.out_byte_en  = 1'b1;
      bus.overflow_clr = 1'b1;
      @(negedge clk);
      bus.out_byte_en  = 1'b0;
      bus.overflow_clr = 1'b0;
      check("clr_vs_drop", 32'(bus.overflow), 1);
      bus.overflow_clr = 1'b1;
      @(negedge clk);
      bus.overflow_clr = 1'b0;
      check("clr_alone", 32'(bus.overflow), 0);
      cnt = 0;
      while (bus.busy && cnt < 400) begin
         @(negedge clk);
         cnt++;
      end
      check("drain_idle", 32'(bus.busy), 0);

      // reset during DATA bit 3
      push_one(8'h55);
      push_one(8'h66);
      bus.out_byte_en = 1'b0;
      repeat (17) @(negedge clk);
      check("bit3_low", 32'(bus.tx), 0);
      #2 resetn = 1'b0;
      #1;
      check("async_rst_tx", 32'(bus.tx), 1);
      check("async_rst_level", 32'(bus.fifo_level), 0);
      check("async_rst_busy", 32'(bus.busy), 0);
      @(negedge clk);
      resetn = 1'b1;
      repeat (60) @(negedge clk);
      check("post_rst_level", 32'(bus.fifo_level), 0);
      check("post_rst_busy", 32'(bus.busy), 0);
      check("post_rst_tx", 32'(bus.tx), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/soc_uart_tx.md
SOC_UART_TX -- requirements
Module: soc_uart_tx

Interface
REQ-001 Parameter CLK_DIV, default 868, clock cycles per serial bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 16, byte entries in transmit FIFO; power of two, 2..256.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset; assertion takes effect immediately, deassertion is sampled on clk.
REQ-005 out_byte  input  8  byte from the CPU console write path; valid only while out_byte_en is high.
REQ-006 out_byte_en  input  1  one-cycle write strobe; one byte is offered per high cycle.
REQ-007 tx  output  1  serial line, 8N1, idle high.
REQ-008 busy  output  1  high while the FIFO is non-empty or a frame is in progress.
REQ-009 fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy, 0..FIFO_DEPTH.
REQ-010 overflow  output  1  sticky flag: at least one byte was dropped because the FIFO was full.
REQ-011 overflow_clr  input  1  synchronous clear of overflow.

Function
REQ-012 Push: in a cycle with out_byte_en=1, the SHALL accept rule is fifo_level<FIFO_DEPTH, or a pop in the same cycle; out_byte is written at the FIFO tail on that edge.
REQ-013 Drop: out_byte_en=1 with FIFO full and no same-cycle pop SHALL discard the byte, leave fifo_level unchanged and set overflow on that edge.
REQ-014 overflow_clr=1 SHALL clear overflow on the next edge; a same-cycle drop wins (overflow stays 1).
REQ-015 fifo_level SHALL increment on push-only, decrement on pop-only, and hold on push+pop or neither; pointers wrap modulo FIFO_DEPTH.
REQ-016 FSM states: IDLE, START, DATA, STOP; a bit counter (0..7) and a baud counter (0..CLK_DIV-1) accompany the FSM.
REQ-017 IDLE: tx=1; if the FIFO is non-empty, pop the head into the shift register, clear the baud counter and enter START on the same edge.
REQ-018 START: tx=0 for exactly CLK_DIV cycles, then enter DATA with the bit counter at 0.
REQ-019 DATA: tx equals shift register bit 0, LSB first, each bit held CLK_DIV cycles; shift right after each bit; enter STOP after bit 7.
REQ-020 STOP: tx=1 for CLK_DIV cycles; at the final cycle, if the FIFO is non-empty, pop and enter START directly (back-to-back), else enter IDLE.
REQ-021 Frame length SHALL be exactly 10*CLK_DIV cycles; back-to-back frames SHALL leave no idle gap.
REQ-022 Latency: a byte pushed into an empty FIFO while in IDLE SHALL drive tx low beginning one cycle after the push edge.
REQ-023 tx SHALL be registered (no combinational path from inputs to tx).
REQ-024 Pop occurs only in IDLE or at the end of STOP; a push to an empty FIFO in the same cycle as a pop check is not visible until the next cycle.
REQ-025 busy SHALL be computed as (state!=IDLE) OR (fifo_level!=0).

Reset
REQ-026 While resetn=0: tx=1, state=IDLE, fifo_level=0, overflow=0, busy=0, and all counters are 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately (tx returns to 1 asynchronously) and discard all FIFO contents.
REQ-028 FIFO storage contents need no reset; only pointers and the count are reset.

Verification (CLK_DIV=4, FIFO_DEPTH=4)
REQ-029 Push 0xA5 once from idle -> tx low one cycle after the push, then bits 1,0,1,0,0,1,0,1 with 4 cycles each, then high for 4 cycles; total 40 cycles; busy falls after STOP.
REQ-030 Push 0x01,0x02 on consecutive cycles -> two frames totaling 80 cycles with no gap; fifo_level sequence 1,1,0 as pops occur.
REQ-031 Push 6 bytes on consecutive cycles from idle -> first is popped immediately; 4 are queued; the 6th is dropped; overflow=1; exactly 5 frames are transmitted.
REQ-032 With FIFO full, push in the STOP-final cycle -> the byte is accepted (simultaneous pop), fifo_level unchanged, overflow stays 0.
REQ-033 Assert overflow_clr together with a dropping push -> overflow remains 1; a following clr alone -> 0.
REQ-034 Assert resetn=0 during DATA bit 3 -> tx=1 immediately; after release, fifo_level=0, busy=0, no further frames.
